// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Owns the byte-wide unified RAM port. Arbitrates store commits,
//            load-buffer reads and instruction fetches (store > load > fetch),
//            splits each access into byte beats, reassembles/extends reads and
//            broadcasts load results on the mem_* CDB channel.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int          ROB_SIZE_WIDTH = 3,
  parameter logic [31:0] IO_ADDR_MASK   = 32'h00030000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      io_buffer_full,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      lb2mem_ready,
  input  logic [2:0]                lb2mem_load_type,
  input  logic [31:0]               lb2mem_addr,
  input  logic [ROB_SIZE_WIDTH:0]   lb2mem_dependency,
  output logic                      mem_busy,
  output logic                      mem_valid,
  output logic [ROB_SIZE_WIDTH:0]   mem_dependency,
  output logic [31:0]               mem_value,
  input  logic                      st_valid,
  input  logic [31:0]               st_addr,
  input  logic [31:0]               st_value,
  input  logic [1:0]                st_width,
  output logic                      st_done,
  input  logic                      if_valid,
  input  logic [31:0]               if_addr,
  output logic [31:0]               if_data,
  output logic                      if_done
);

  localparam int TW = ROB_SIZE_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [1:0]      cnt;
  // The RAM answers one edge after it samples the address, so the first edge
  // of a read only advances the address; "primed" marks data now flowing.
  logic            primed;
  logic [31:0]     data_buf;
  logic [1:0]      st_size;
  logic [2:0]      cur_type;
  logic [TW-1:0]   cur_tag;

  logic            load_pend;
  logic [2:0]      pend_type;
  logic [31:0]     pend_addr;
  logic [TW-1:0]   pend_tag;

  logic            st_stall;
  logic            load_req;
  logic            fetch_req;
  logic            take_store;
  logic            take_load;
  logic            take_fetch;
  logic [1:0]      rd_last_idx;
  logic            rd_last;
  logic            st_last;
  logic [31:0]     rd_word;
  logic [31:0]     ld_ext;

  assign mem_busy = (state != IDLE) || load_pend;

  // Arbitration, beat-completion decode, read assembly and next state
  always_comb begin
    st_stall   = ((st_addr & IO_ADDR_MASK) == IO_ADDR_MASK) && io_buffer_full;
    load_req   = !need_flush_in && (load_pend || lb2mem_ready);
    fetch_req  = !need_flush_in && if_valid;
    // A stalled store still holds the port so it is not overtaken.
    take_store = (state == IDLE) && st_valid && !st_stall;
    take_load  = (state == IDLE) && !st_valid && load_req;
    take_fetch = (state == IDLE) && !st_valid && !load_req && fetch_req;

    if (state == FETCH) begin
      rd_last_idx = 2'd3;
    end else begin
      case (cur_type[1:0])
        2'b00:   rd_last_idx = 2'd0;
        2'b01:   rd_last_idx = 2'd1;
        default: rd_last_idx = 2'd3;
      endcase
    end
    rd_last = primed && (cnt == rd_last_idx);

    // cnt counts bytes already driven; a word wraps the 2-bit counter to 0.
    case (st_size)
      2'b00:   st_last = (cnt == 2'd1);
      2'b01:   st_last = (cnt == 2'd2);
      default: st_last = (cnt == 2'd0);
    endcase

    rd_word = data_buf;
    rd_word[{cnt, 3'b000} +: 8] = mem_din;

    case (cur_type)
      3'b000:  ld_ext = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b001:  ld_ext = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b100:  ld_ext = {24'd0, rd_word[7:0]};
      3'b101:  ld_ext = {16'd0, rd_word[15:0]};
      default: ld_ext = rd_word;
    endcase

    state_next = state;
    case (state)
      IDLE: begin
        if (take_store)      state_next = STORE;
        else if (take_load)  state_next = LOAD;
        else if (take_fetch) state_next = FETCH;
      end
      LOAD, FETCH: begin
        if (need_flush_in || rd_last) state_next = IDLE;
      end
      STORE: begin
        if (st_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_next;
    end
  end

  // Pending-load register: holds a load pulse that could not start at once
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      load_pend <= 1'b0;
      pend_type <= 3'd0;
      pend_addr <= 32'd0;
      pend_tag  <= '1;
    end else if (rdy_in) begin
      if (need_flush_in || take_load) begin
        load_pend <= 1'b0;
      end else if (lb2mem_ready) begin
        load_pend <= 1'b1;
        pend_type <= lb2mem_load_type;
        pend_addr <= lb2mem_addr;
        pend_tag  <= lb2mem_dependency;
      end
    end
  end

  // RAM port beats, read assembly and result/completion pulses
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_a          <= 32'd0;
      mem_dout       <= 8'd0;
      mem_wr         <= 1'b0;
      cnt            <= 2'd0;
      primed         <= 1'b0;
      data_buf       <= 32'd0;
      st_size        <= 2'd0;
      cur_type       <= 3'd0;
      cur_tag        <= '1;
      mem_valid      <= 1'b0;
      mem_dependency <= '1;
      mem_value      <= 32'd0;
      st_done        <= 1'b0;
      if_data        <= 32'd0;
      if_done        <= 1'b0;
    end else if (rdy_in) begin
      mem_valid <= 1'b0;
      st_done   <= 1'b0;
      if_done   <= 1'b0;
      case (state)
        IDLE: begin
          mem_wr <= 1'b0;
          if (take_store) begin
            mem_a    <= st_addr;
            mem_dout <= st_value[7:0];
            mem_wr   <= 1'b1;
            cnt      <= 2'd1;
            data_buf <= st_value;
            st_size  <= st_width;
          end else if (take_load) begin
            mem_a    <= load_pend ? pend_addr : lb2mem_addr;
            cur_type <= load_pend ? pend_type : lb2mem_load_type;
            cur_tag  <= load_pend ? pend_tag  : lb2mem_dependency;
            cnt      <= 2'd0;
            primed   <= 1'b0;
          end else if (take_fetch) begin
            mem_a    <= if_addr;
            cnt      <= 2'd0;
            primed   <= 1'b0;
          end
        end
        LOAD, FETCH: begin
          mem_wr <= 1'b0;
          if (!need_flush_in) begin
            mem_a <= mem_a + 32'd1;
            if (!primed) begin
              primed <= 1'b1;
            end else begin
              data_buf[{cnt, 3'b000} +: 8] <= mem_din;
              cnt <= cnt + 2'd1;
              if (rd_last) begin
                if (state == LOAD) begin
                  mem_valid      <= 1'b1;
                  mem_dependency <= cur_tag;
                  mem_value      <= ld_ext;
                end else begin
                  if_data <= rd_word;
                  if_done <= 1'b1;
                end
              end
            end
          end
        end
        STORE: begin
          // A committed store always finishes, flush or not.
          if (st_last) begin
            mem_wr  <= 1'b0;
            st_done <= 1'b1;
          end else begin
            mem_a    <= mem_a + 32'd1;
            mem_dout <= data_buf[{cnt, 3'b000} +: 8];
            cnt      <= cnt + 2'd1;
          end
        end
        default: mem_wr <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a synchronous
//            byte RAM model (read data one edge after address sampling).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        need_flush_in = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        lb2mem_ready = 1'b0;
  logic [2:0]  lb2mem_load_type = 3'd0;
  logic [31:0] lb2mem_addr = 32'd0;
  logic [3:0]  lb2mem_dependency = 4'd0;
  logic        mem_busy;
  logic        mem_valid;
  logic [3:0]  mem_dependency;
  logic [31:0] mem_value;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_value = 32'd0;
  logic [1:0]  st_width = 2'd0;
  logic        st_done;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_data;
  logic        if_done;

  always #5 clk = ~clk;

  mem_arbiter #(.ROB_SIZE_WIDTH(3), .IO_ADDR_MASK(32'h00030000)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .lb2mem_ready(lb2mem_ready),
    .lb2mem_load_type(lb2mem_load_type), .lb2mem_addr(lb2mem_addr),
    .lb2mem_dependency(lb2mem_dependency), .mem_busy(mem_busy),
    .mem_valid(mem_valid), .mem_dependency(mem_dependency), .mem_value(mem_value),
    .st_valid(st_valid), .st_addr(st_addr), .st_value(st_value), .st_width(st_width),
    .st_done(st_done), .if_valid(if_valid), .if_addr(if_addr), .if_data(if_data),
    .if_done(if_done)
  );

  // Synchronous RAM model, enabled together with the core
  logic [7:0] ram [0:4095];
  logic [7:0] rdata = 8'd0;
  int         wr_count = 0;
  assign mem_din = rdata;
  always @(posedge clk) begin
    if (rdy_in) begin
      if (mem_wr) begin
        ram[mem_a[11:0]] <= mem_dout;
        wr_count <= wr_count + 1;
      end
      rdata <= ram[mem_a[11:0]];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  ltype;
    logic [31:0] addr;
    logic [31:0] bytes;
    logic [3:0]  tag;
    logic [31:0] exp_val;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  // Issue one load pulse; latency counts edges after the pulse edge.
  task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [3:0] tag,
                          output int lat, output logic [31:0] val, output logic [3:0] dep,
                          output logic busy_ok);
    lat = -1; val = 32'd0; dep = 4'd0; busy_ok = 1'b1;
    @(negedge clk);
    lb2mem_ready = 1'b1; lb2mem_load_type = t; lb2mem_addr = a; lb2mem_dependency = tag;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lb2mem_ready = 1'b0;
      if (mem_valid) begin
        lat = k; val = mem_value; dep = mem_dependency;
        break;
      end
      if (!mem_busy) busy_ok = 1'b0;
    end
  endtask

  int          lat, t_st, t_ld, t_if, w0;
  logic [31:0] val, v_ld, v_if, a_before, a_after;
  logic [3:0]  dep;
  logic        busy_ok, seen;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'd0;
    vecs[0] = '{3'b010, 32'h100, 32'h44332211, 4'd5, 32'h44332211, 5};
    vecs[1] = '{3'b000, 32'h110, 32'h00000080, 4'd1, 32'hFFFFFF80, 2};
    vecs[2] = '{3'b100, 32'h110, 32'h00000080, 4'd2, 32'h00000080, 2};
    vecs[3] = '{3'b001, 32'h120, 32'h0000F234, 4'd3, 32'hFFFFF234, 3};
    vecs[4] = '{3'b101, 32'h120, 32'h0000F234, 4'd4, 32'h0000F234, 3};
    vecs[5] = '{3'b010, 32'h131, 32'h04030201, 4'd7, 32'h04030201, 5};
    vecs[6] = '{3'b000, 32'h140, 32'h9999997F, 4'd0, 32'h0000007F, 2};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_st_done", {31'd0, st_done}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_mem_dep", {28'd0, mem_dependency}, 32'hF);
    check("rst_mem_busy", {31'd0, mem_busy}, 32'd0);
    rst_in = 1'b0;

    // Table-driven loads
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 4; b++) ram[12'(vecs[i].addr + 32'(b))] = vecs[i].bytes[b*8 +: 8];
      run_load(vecs[i].ltype, vecs[i].addr, vecs[i].tag, lat, val, dep, busy_ok);
      check($sformatf("ld%0d_value", i), val, vecs[i].exp_val);
      check($sformatf("ld%0d_dep", i), {28'd0, dep}, {28'd0, vecs[i].tag});
      check($sformatf("ld%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("ld%0d_busy_held", i), {31'd0, busy_ok}, 32'd1);
      @(negedge clk);
      check($sformatf("ld%0d_pulse_one_cycle", i), {31'd0, mem_valid}, 32'd0);
    end

    // Simultaneous store, load pulse and fetch
    ram[12'h300] = 8'h13; ram[12'h301] = 8'h00; ram[12'h302] = 8'h00; ram[12'h303] = 8'h93;
    for (int b = 0; b < 4; b++) ram[12'h100 + 12'(b)] = vecs[0].bytes[b*8 +: 8];
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h200; st_value = 32'hDEADBEEF; st_width = 2'b10;
    lb2mem_ready = 1'b1; lb2mem_load_type = 3'b010; lb2mem_addr = 32'h100; lb2mem_dependency = 4'd3;
    if_valid = 1'b1; if_addr = 32'h300;
    t_st = -1; t_ld = -1; t_if = -1; busy_ok = 1'b1; v_ld = 32'd0; v_if = 32'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lb2mem_ready = 1'b0;
      if (st_done && t_st < 0) begin t_st = k; st_valid = 1'b0; end
      if (mem_valid && t_ld < 0) begin t_ld = k; v_ld = mem_value; end
      if (if_done && t_if < 0) begin t_if = k; v_if = if_data; if_valid = 1'b0; end
      if (t_ld < 0 && !mem_busy) busy_ok = 1'b0;
    end
    if_valid = 1'b0; st_valid = 1'b0;
    check("sim_store_done_t", 32'(t_st), 32'd4);
    check("sim_ram_bytes", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hDEADBEEF);
    check("sim_load_t", 32'(t_ld), 32'd10);
    check("sim_load_val", v_ld, 32'h44332211);
    check("sim_fetch_t", 32'(t_if), 32'd16);
    check("sim_fetch_val", v_if, 32'h93000013);
    check("sim_busy_held", {31'd0, busy_ok}, 32'd1);

    // Flush mid-LOAD after two bytes captured
    @(negedge clk);
    lb2mem_ready = 1'b1; lb2mem_load_type = 3'b010; lb2mem_addr = 32'h100; lb2mem_dependency = 4'd2;
    @(negedge clk); lb2mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    need_flush_in = 1'b1;
    @(negedge clk);
    need_flush_in = 1'b0;
    check("flush_ld_idle", {31'd0, mem_busy}, 32'd0);
    check("flush_ld_wr", {31'd0, mem_wr}, 32'd0);
    seen = mem_valid;
    repeat (8) begin
      @(negedge clk);
      if (mem_valid) seen = 1'b1;
    end
    check("flush_ld_no_valid", {31'd0, seen}, 32'd0);

    // Flush during a single-byte store
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h210; st_value = 32'h00000055; st_width = 2'b00;
    @(negedge clk);
    need_flush_in = 1'b1;
    @(negedge clk);
    need_flush_in = 1'b0;
    check("flush_sb_done", {31'd0, st_done}, 32'd1);
    st_valid = 1'b0;
    @(negedge clk);
    check("flush_sb_ram", {24'd0, ram[12'h210]}, 32'h55);

    // I/O stall
    @(negedge clk);
    w0 = wr_count;
    st_valid = 1'b1; st_addr = 32'h00030000; st_value = 32'h000000A5; st_width = 2'b00;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("io_stall_wr%0d", k), {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_accept_wr", {31'd0, mem_wr}, 32'd1);
    check("io_accept_addr", mem_a, 32'h00030000);
    @(negedge clk);
    check("io_done", {31'd0, st_done}, 32'd1);
    st_valid = 1'b0;
    check("io_ram", {24'd0, ram[12'h000]}, 32'hA5);
    check("io_write_count", 32'(wr_count - w0), 32'd1);

    // rdy_in low for three edges mid-LW
    @(negedge clk);
    lb2mem_ready = 1'b1; lb2mem_load_type = 3'b010; lb2mem_addr = 32'h100; lb2mem_dependency = 4'd6;
    lat = -1; val = 32'd0; a_before = 32'd0; a_after = 32'd1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      lb2mem_ready = 1'b0;
      if (k == 2) begin a_before = mem_a; rdy_in = 1'b0; end
      if (k == 5) begin a_after = mem_a; rdy_in = 1'b1; end
      if (mem_valid) begin lat = k; val = mem_value; break; end
    end
    rdy_in = 1'b1;
    check("rdy_addr_frozen", a_after, a_before);
    check("rdy_latency", 32'(lat), 32'd8);
    check("rdy_value", val, 32'h44332211);

    // Async reset mid-STORE while rdy_in is low
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h220; st_value = 32'h11223344; st_width = 2'b10;
    repeat (2) @(negedge clk);
    check("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
    rdy_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    check("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("arst_mem_a", mem_a, 32'd0);
    check("arst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("arst_busy", {31'd0, mem_busy}, 32'd0);
    check("arst_dep", {28'd0, mem_dependency}, 32'hF);
    check("arst_value", mem_value, 32'd0);
    check("arst_if_data", if_data, 32'd0);
    st_valid = 1'b0;
    @(negedge clk);
    rst_in = 1'b0; rdy_in = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single owner of the byte-wide unified RAM port.
- Arbitrates among three requesters:
  - store commits from the ROB / store buffer,
  - loads issued by the load buffer (`lb2mem_*`),
  - instruction-word fetches from the fetch unit.
- Serializes each access into byte beats and reassembles or sign-extends read data.
- Broadcasts load results on the `mem_*` CDB channel consumed by the LSB, RS and ROB.

Parameters:
- ROB_SIZE_WIDTH, 3, ROB index width; dependency tags are ROB_SIZE_WIDTH+1 bits, all-ones = none.
- IO_ADDR_MASK, 32'h00030000, any address with `(addr & IO_ADDR_MASK) == IO_ADDR_MASK` is I/O space.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- need_flush_in  in  1  misprediction flush.
- io_buffer_full  in  1  UART buffer full.
- mem_din  in  8  RAM read byte; valid one cycle after `mem_a` is presented.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- lb2mem_ready  in  1  one-cycle load request pulse.
- lb2mem_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- lb2mem_addr  in  32  load address.
- lb2mem_dependency  in  ROB_SIZE_WIDTH+1  tag of the load.
- mem_busy  out  1  combinational: `(state != IDLE) || load_pend`.
- mem_valid  out  1  one-cycle load result pulse.
- mem_dependency  out  ROB_SIZE_WIDTH+1  result tag.
- mem_value  out  32  extended load data.
- st_valid  in  1  store request; held until `st_done`.
- st_addr  in  32  store address.
- st_value  in  32  store data.
- st_width  in  2  00 byte, 01 half, 10 word.
- st_done  out  1  one-cycle completion pulse.
- if_valid  in  1  fetch request; level, may drop on flush.
- if_addr  in  32  fetch address (word).
- if_data  out  32  fetched instruction.
- if_done  out  1  one-cycle completion pulse.

Behaviour:
- **Reset (async, any time, including mid-access)**
  - State IDLE, `load_pend` = 0.
  - `mem_a`, `mem_dout`, `if_data`, `mem_value` = 0.
  - `mem_wr`, `mem_valid`, `st_done`, `if_done` = 0.
  - `mem_dependency` = all-ones.
- **`rdy_in` low:** all registers hold, including `mem_wr`.
- **Load capture:** `lb2mem_ready` is latched into the pending-load register every enabled edge in which it is high. The LSB only pulses when `mem_busy` = 0, so no overwrite is possible.
- **States:** IDLE, LOAD, FETCH, STORE. Byte counter `cnt` is 2 bits; N = access bytes (1/2/4).
- **IDLE arbitration, evaluated each enabled edge. Priority: store > load (pending or same-edge pulse) > fetch.**
  - **Store win:**
    - Stall-hold applies if the address is I/O and `io_buffer_full` = 1: remain IDLE, `mem_wr` = 0.
    - Otherwise `mem_a` <= `st_addr`, `mem_dout` <= `st_value[7:0]`, `mem_wr` <= 1, `cnt` <= 1, go to STORE.
  - **Load win:** `mem_a` <= address, `mem_wr` <= 0, `cnt` <= 0, clear pending, go to LOAD.
  - **Fetch win:** same as a load of 4 bytes, go to FETCH.
  - A store won on the same edge as a load pulse: the load goes to pending.
- **LOAD / FETCH (one byte per edge)**
  - Each edge: byte[`cnt`] <= `mem_din`, `mem_a` <= `mem_a` + 1.
  - On the edge capturing byte N-1:
    - LOAD: `mem_valid` <= 1, `mem_dependency` <= tag, `mem_value` <= assembled little-endian data. LB/LH sign-extend; LBU/LHU zero-extend.
    - FETCH: `if_data`, `if_done` <= 1.
    - Return to IDLE.
  - Result appears exactly N+1 edges after acceptance, and is asserted for exactly one cycle.
- **STORE**
  - Each edge drives byte[`cnt`] at `mem_a` + 1 with `mem_wr` = 1.
  - After byte N-1 is driven: `mem_wr` <= 0, `st_done` <= 1, go to IDLE. Done is high N edges after acceptance.
  - A single-byte store completes on the edge after acceptance.
- **Flush (`need_flush_in` = 1, enabled edge)**
  - LOAD or FETCH: go to IDLE immediately, no result pulse, `mem_wr` = 0.
  - `load_pend` is cleared, and a same-edge `lb2mem_ready` is ignored.
  - STORE: always completes (the store is committed).
  - `mem_valid` and `if_done` <= 0.
- **Pulse outputs** (`mem_valid`, `st_done`, `if_done`) clear on the next enabled edge.
- **Addresses:** increment wraps modulo 2^32. No alignment requirement.
- **Back-to-back:** a new access may be accepted on the edge after return to IDLE, so there is one idle cycle between accesses.

Test Plan:
- **LW:** RAM[0x100..0x103] = 11,22,33,44, tag 5 pulse in IDLE -> `mem_valid` one cycle, `mem_value` = 0x44332211, `mem_dependency` = 5, 5 edges after the pulse; `mem_busy` high throughout.
- **Extension:** LB at a byte 0x80 -> 0xFFFFFF80; LBU -> 0x00000080; LH of bytes 0x34,0xF2 -> 0xFFFFF234.
- **Simultaneous requests:** SW 0xDEADBEEF @0x200, load pulse, and `if_valid` all in one edge -> bytes EF,BE,AD,DE written to 0x200-0x203, then `st_done`. Then the load completes. Then the fetch completes with `if_done`. `mem_busy` never drops while the load is pending.
- **Flush mid-LOAD** (after 2 bytes) -> no `mem_valid`, IDLE next cycle. Flush during SB -> the write still occurs and `st_done` still fires.
- **I/O stall:** SB to 0x30000 with `io_buffer_full` = 1 for 3 cycles -> `mem_wr` stays 0. Write occurs the edge after it drops.
- **Async reset mid-STORE and with `rdy_in` low:** all outputs reset values immediately. `rdy_in` low mid-LW freezes `cnt`/`mem_a`; the result is delayed by exactly the stall length.
